// File: rtl/demux_1x16_using_1x4_pkg.sv
// ---------------------------------------------------------------------------
// demux_1x16_using_1x4_pkg
//
// Purpose:
//   Shared sizing constants for the hierarchical 1-to-16 demultiplexer.
//   The top level and its 1-to-4 building block both import this package,
//   so the lane count and select width are defined in one place.
//
// Contents:
//   N_OUT   number of output lanes on the full demux (16)
//   SEL_W   width of the full lane select (4)
//   FANOUT  lanes produced by one 1-to-4 cell (4)
//   CELL_W  select bits consumed by one 1-to-4 cell (2)
// ---------------------------------------------------------------------------
package demux_1x16_using_1x4_pkg;

    localparam int N_OUT  = 16;
    localparam int SEL_W  = 4;
    localparam int FANOUT = 4;
    localparam int CELL_W = 2;

endpackage : demux_1x16_using_1x4_pkg

// File: rtl/demux_1x16_using_1x4_demux_1x4.sv
// ---------------------------------------------------------------------------
// demux_1x4
//
// Purpose:
//   Purely combinational 1-to-4 demultiplexer cell. The data input is copied
//   onto the lane picked by sel; every other lane is driven to zero.
//
// Ports:
//   din  in   DATA_W           data to be routed
//   sel  in   CELL_W           lane select, 0..3
//   y    out  FANOUT*DATA_W    lane j = y[j*DATA_W +: DATA_W]
// ---------------------------------------------------------------------------
module demux_1x4
    import demux_1x16_using_1x4_pkg::*;
#(
    parameter int DATA_W = 1
) (
    input  logic [DATA_W-1:0]        din,
    input  logic [CELL_W-1:0]        sel,
    output logic [FANOUT*DATA_W-1:0] y
);

    // Start from an all-zero bus so only the selected lane ever carries
    // data; the loop then drops din into the one matching slot.
    always_comb begin
        y = '0;
        for (int j = 0; j < FANOUT; j++) begin
            if (sel == CELL_W'(j)) begin
                y[j*DATA_W +: DATA_W] = din;
            end
        end
    end

endmodule : demux_1x4

// File: rtl/demux_1x16_using_1x4.sv
// ---------------------------------------------------------------------------
// demux_1x16_using_1x4
//
// Purpose:
//   Registered 1-to-16 demultiplexer built from a tree of five 1-to-4 cells.
//   The upper select bits pick one of four groups, the lower select bits
//   pick the lane within that group. The decoded bus is registered once so
//   downstream logic sees a clean, glitch-free output one cycle after
//   din/sel are presented.
//
// Ports:
//   clk   in   1              rising-edge clock
//   rst   in   1              synchronous, active-high reset (clears y)
//   din   in   DATA_W         data to be routed
//   sel   in   SEL_W          lane select, 0..15
//   y     out  N_OUT*DATA_W   lane k = y[k*DATA_W +: DATA_W]; registered
// ---------------------------------------------------------------------------
module demux_1x16_using_1x4
    import demux_1x16_using_1x4_pkg::*;
#(
    parameter int DATA_W = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       din,
    input  logic [SEL_W-1:0]        sel,
    output logic [N_OUT*DATA_W-1:0] y
);

    logic [FANOUT*DATA_W-1:0] groupBus;
    logic [N_OUT*DATA_W-1:0]  laneBus;
    logic [N_OUT*DATA_W-1:0]  y_d;
    logic [N_OUT*DATA_W-1:0]  y_q;

    // First stage: the two high select bits choose which group of four
    // lanes receives the data.
    demux_1x4 #(
        .DATA_W (DATA_W)
    ) u_stage1 (
        .din (din),
        .sel (sel[SEL_W-1:CELL_W]),
        .y   (groupBus)
    );

    // Second stage: each group output is split again by the two low select
    // bits, so group i feeds lanes 4*i .. 4*i+3. Groups that did not get
    // the data carry zero and therefore produce all-zero lanes.
    for (genvar i = 0; i < FANOUT; i++) begin : g_stage2
        demux_1x4 #(
            .DATA_W (DATA_W)
        ) u_stage2 (
            .din (groupBus[i*DATA_W +: DATA_W]),
            .sel (sel[CELL_W-1:0]),
            .y   (laneBus[i*FANOUT*DATA_W +: FANOUT*DATA_W])
        );
    end

    // Next-state of the output register is simply the decoded lane bus.
    always_comb begin
        y_d = laneBus;
    end

    // Output register: reset wins over any din/sel, otherwise capture the
    // freshly decoded lanes. din and sel are sampled on the same edge, so a
    // simultaneous change can never produce a mixed result.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

    assign y = y_q;

endmodule : demux_1x16_using_1x4

// File: tb/tb_demux_1x16_using_1x4.sv
// ---------------------------------------------------------------------------
// tb_demux_1x16_using_1x4
//
// Purpose:
//   Self-checking bench for the registered 1-to-16 demultiplexer. Directed
//   steps cover reset, a select walk, zero data, simultaneous changes and a
//   mid-run reset, followed by a randomized run checked against a simple
//   one-hot reference model.
// ---------------------------------------------------------------------------
module tb_demux_1x16_using_1x4;

    logic        clk;
    logic        rst;
    logic [0:0]  din;
    logic [3:0]  sel;
    logic [15:0] y;

    int          total;
    int          bad;
    logic [15:0] expY;

    demux_1x16_using_1x4 #(
        .DATA_W (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .din (din),
        .sel (sel),
        .y   (y)
    );

    // 10 ns clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: after an edge the output is zero under reset, otherwise a
    // single 1 at bit position sel when din is 1, else zero.
    function automatic logic [15:0] modelLanes(input logic r, input logic d,
                                               input logic [3:0] s);
        if (r || !d) return 16'h0000;
        return 16'h0001 << s;
    endfunction

    // Compare the current output against a bench-computed expectation.
    task automatic checkOutput(input string tag, input logic [15:0] want);
        total++;
        assert (y === want) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, y, want);
        end
    endtask

    // Present inputs, take one rising edge, then sample 1 ns later and
    // update the expected output from the values that were sampled.
    task automatic applyStimulus(input logic r, input logic d,
                                 input logic [3:0] s);
        rst = r;
        din = d;
        sel = s;
        @(posedge clk);
        expY = modelLanes(r, d, s);
        #1;
    endtask

    initial begin
        logic       rR;
        logic       dR;
        logic [3:0] sR;

        total = 0;
        bad   = 0;
        rst   = 1'b1;
        din   = 1'b0;
        sel   = 4'd0;
        expY  = 16'h0000;

        // Reset held for two cycles with active data on the inputs.
        applyStimulus(1'b1, 1'b1, 4'd5);
        checkOutput("reset_c1", 16'h0000);
        applyStimulus(1'b1, 1'b1, 4'd5);
        checkOutput("reset_c2", 16'h0000);
        applyStimulus(1'b0, 1'b1, 4'd5);
        checkOutput("reset_release", 16'h0020);

        // Walk the select through every lane with din=1.
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b0, 1'b1, 4'(k));
            checkOutput($sformatf("walk_%0d", k), 16'h0001 << k);
        end

        // With zero data every lane stays zero whatever the select.
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b0, 1'b0, 4'(k));
            checkOutput($sformatf("zero_%0d", k), 16'h0000);
        end

        // Simultaneous select change; also confirm y holds between edges.
        applyStimulus(1'b0, 1'b1, 4'd3);
        checkOutput("simul_before", 16'h0008);
        sel = 4'd12;
        #2;
        checkOutput("simul_hold", 16'h0008);
        applyStimulus(1'b0, 1'b1, 4'd12);
        checkOutput("simul_after", 16'h1000);

        // Reset in the middle of operation, then recovery.
        applyStimulus(1'b0, 1'b1, 4'd15);
        checkOutput("midrst_pre", 16'h8000);
        applyStimulus(1'b1, 1'b1, 4'd15);
        checkOutput("midrst_on", 16'h0000);
        applyStimulus(1'b0, 1'b1, 4'd15);
        checkOutput("midrst_off", 16'h8000);

        // Randomized run with occasional resets.
        for (int n = 0; n < 1000; n++) begin
            rR = ($urandom_range(0, 31) == 0);
            dR = 1'($urandom_range(0, 1));
            sR = 4'($urandom_range(0, 15));
            applyStimulus(rR, dR, sR);
            total++;
            assert ($countones(y) <= 1) else begin
                bad++;
                $error("[TB] FAIL onehot_%0d observed=%h expected=at_most_one_bit",
                       n, y);
            end
            checkOutput($sformatf("rand_%0d", n), expY);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_demux_1x16_using_1x4
